// File: rtl/alu_operand_stage_if.sv
// Decode-side, bypass and ALU-side signals of the operand stage.
// The slave modport is the operand stage; the master modport is the surrounding pipeline.
interface alu_operand_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1_addr;
  logic [4:0]        in_rs2_addr;
  logic [4:0]        in_rd_addr;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic [3:0]        in_sel;
  logic              in_use_imm;
  logic              in_reg_write;
  logic              in_mem_read;

  logic [4:0]        exm_rd_addr;
  logic              exm_reg_write;
  logic              exm_mem_read;
  logic [DATA_W-1:0] exm_result;
  logic [4:0]        mwb_rd_addr;
  logic              mwb_reg_write;
  logic [DATA_W-1:0] mwb_result;

  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_store_data;
  logic [3:0]        out_sel;
  logic [4:0]        out_rd_addr;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              stall;

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
    input  in_imm, in_pc, in_sel, in_use_imm, in_reg_write, in_mem_read,
    input  exm_rd_addr, exm_reg_write, exm_mem_read, exm_result,
    input  mwb_rd_addr, mwb_reg_write, mwb_result, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_store_data, out_sel, out_rd_addr,
    output out_reg_write, out_mem_read, stall
  );

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
    output in_imm, in_pc, in_sel, in_use_imm, in_reg_write, in_mem_read,
    output exm_rd_addr, exm_reg_write, exm_mem_read, exm_result,
    output mwb_rd_addr, mwb_reg_write, mwb_result, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_store_data, out_sel, out_rd_addr,
    input  out_reg_write, out_mem_read, stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Single-entry operand stage between decode and ALU: holds one instruction, bypasses results
// and detects load-use hazards. Define ALU_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module alu_operand_stage #(
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  alu_operand_stage_if.slave bus
);
  logic              full_q, full_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [3:0]        sel_q, sel_d;
  logic              use_imm_q, use_imm_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;

  logic              exm_hit1, exm_hit2, mwb_hit1, mwb_hit2;
  logic              hazard, out_valid, capture, drain;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
  logic              unused_sink;

  // Register 0 never matches, so it is neither forwarded, snooped nor stalled on.
  assign exm_hit1 = (rs1_addr_q != 5'd0) && (rs1_addr_q == bus.exm_rd_addr) && bus.exm_reg_write;
  assign exm_hit2 = (rs2_addr_q != 5'd0) && (rs2_addr_q == bus.exm_rd_addr) && bus.exm_reg_write;
  assign mwb_hit1 = (rs1_addr_q != 5'd0) && (rs1_addr_q == bus.mwb_rd_addr) && bus.mwb_reg_write;
  assign mwb_hit2 = (rs2_addr_q != 5'd0) && (rs2_addr_q == bus.mwb_rd_addr) && bus.mwb_reg_write;

`ifdef ALU_FWD_EN
  assign rs1_fwd     = exm_hit1 ? bus.exm_result : (mwb_hit1 ? bus.mwb_result : rs1_data_q);
  assign rs2_fwd     = exm_hit2 ? bus.exm_result : (mwb_hit2 ? bus.mwb_result : rs2_data_q);
  assign hazard      = full_q && bus.exm_mem_read && (exm_hit1 || exm_hit2);
  assign unused_sink = ^pc_q;
`else
  // Without bypassing, any in-flight EX/MEM writer of a source must drain to MEM/WB first.
  assign rs1_fwd     = rs1_data_q;
  assign rs2_fwd     = rs2_data_q;
  assign hazard      = full_q && (exm_hit1 || exm_hit2);
  assign unused_sink = ^{pc_q, bus.exm_result, bus.exm_mem_read};
`endif

  assign out_valid = full_q && !hazard;
  assign drain     = out_valid && bus.out_ready;
  assign capture   = bus.in_valid && bus.in_ready && !bus.flush;

  assign bus.in_ready       = !full_q || drain;
  assign bus.out_valid      = out_valid;
  assign bus.stall          = hazard;
  assign bus.out_a          = rs1_fwd;
  assign bus.out_b          = use_imm_q ? imm_q : rs2_fwd;
  assign bus.out_store_data = rs2_fwd;
  assign bus.out_sel        = sel_q;
  assign bus.out_rd_addr    = rd_addr_q;
  assign bus.out_reg_write  = reg_write_q;
  assign bus.out_mem_read   = mem_read_q;

  always_comb begin
    full_d      = full_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    sel_d       = sel_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;

    if (bus.flush) begin
      full_d = 1'b0;
    end else if (capture) begin
      full_d      = 1'b1;
      rs1_addr_d  = bus.in_rs1_addr;
      rs2_addr_d  = bus.in_rs2_addr;
      rd_addr_d   = bus.in_rd_addr;
      rs1_data_d  = bus.in_rs1_data;
      rs2_data_d  = bus.in_rs2_data;
      imm_d       = bus.in_imm;
      pc_d        = bus.in_pc;
      sel_d       = bus.in_sel;
      use_imm_d   = bus.in_use_imm;
      reg_write_d = bus.in_reg_write;
      mem_read_d  = bus.in_mem_read;
    end else if (drain) begin
      full_d = 1'b0;
    end

    // Snoop write-back so a held instruction picks up results that retire while it waits.
    if (full_q && !capture) begin
      if (mwb_hit1) rs1_data_d = bus.mwb_result;
      if (mwb_hit2) rs2_data_d = bus.mwb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      sel_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      sel_q       <= sel_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected ALU operands are queued at issue and
// compared when the stage hands them over. Expectations follow ALU_FWD_EN when it is defined.
module tb_alu_operand_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } exp_t;

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  alu_operand_stage_if #(.DATA_W(32)) bus ();
  alu_operand_stage #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {bus.out_a, bus.out_b, bus.out_store_data, bus.out_sel, bus.out_rd_addr,
            bus.out_reg_write, bus.out_mem_read};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    bus.exm_rd_addr   = '0;
    bus.exm_reg_write = 1'b0;
    bus.exm_mem_read  = 1'b0;
    bus.exm_result    = '0;
    bus.mwb_rd_addr   = '0;
    bus.mwb_reg_write = 1'b0;
    bus.mwb_result    = '0;
  endtask

  task automatic set_exm(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] res);
    bus.exm_rd_addr   = rd;
    bus.exm_reg_write = rw;
    bus.exm_mem_read  = mr;
    bus.exm_result    = res;
  endtask

  task automatic set_mwb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    bus.mwb_rd_addr   = rd;
    bus.mwb_reg_write = rw;
    bus.mwb_result    = res;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [3:0] sel, input logic use_imm, input logic rw, input logic mr);
    bus.in_valid     = 1'b1;
    bus.in_rs1_addr  = rs1;
    bus.in_rs2_addr  = rs2;
    bus.in_rd_addr   = rd;
    bus.in_rs1_data  = d1;
    bus.in_rs2_data  = d2;
    bus.in_imm       = imm;
    bus.in_pc        = 32'h0000_1000 + {27'd0, rd};
    bus.in_sel       = sel;
    bus.in_use_imm   = use_imm;
    bus.in_reg_write = rw;
    bus.in_mem_read  = mr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_vec++; if (observed() !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", observed()); end
    tick();
  endtask

  task automatic test_exm_forward();
    exp_t e;
    bit   got;
    drive_instr(5'd5, 5'd6, 5'd9, 32'h10, 32'h20, 32'h1234, 4'd3, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    sb.push_back('{a: (FWD ? 32'h99 : 32'h10), b: 32'h1234, st: 32'h20, sel: 4'd3, rd: 5'd9, rw: 1'b1, mr: 1'b0});
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL exm_fwd_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    set_exm(5'd5, 1'b1, 1'b0, 32'h99);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.out_valid, bus.stall} !== (FWD ? 2'b10 : 2'b01)) begin
      n_err++; $display("FAIL exm_fwd_valid_stall: got %b want %b", {bus.out_valid, bus.stall}, (FWD ? 2'b10 : 2'b01));
    end
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        n_vec++; if (observed() !== e) begin n_err++; $display("FAIL exm_fwd_out: got %h want %h", observed(), e); end
      end
      tick();
      clear_bypass();
    end
    if (!got) begin n_vec++; n_err++; $display("FAIL exm_fwd_timeout: got no handover want one"); end
  endtask

  task automatic test_priority();
    exp_t e;
    bit   got;
    drive_instr(5'd1, 5'd7, 5'd4, 32'h11, 32'h77, 32'h5, 4'd2, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    sb.push_back('{a: 32'h11, b: (FWD ? 32'hAA : 32'hBB), st: (FWD ? 32'hAA : 32'hBB),
                   sel: 4'd2, rd: 5'd4, rw: 1'b1, mr: 1'b0});
    tick();
    bus.in_valid = 1'b0;
    set_exm(5'd7, 1'b1, 1'b0, 32'hAA);
    set_mwb(5'd7, 1'b1, 32'hBB);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.out_valid, bus.stall} !== (FWD ? 2'b10 : 2'b01)) begin
      n_err++; $display("FAIL prio_valid_stall: got %b want %b", {bus.out_valid, bus.stall}, (FWD ? 2'b10 : 2'b01));
    end
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        n_vec++; if (observed() !== e) begin n_err++; $display("FAIL prio_out: got %h want %h", observed(), e); end
      end
      tick();
      clear_bypass();
    end
    if (!got) begin n_vec++; n_err++; $display("FAIL prio_timeout: got no handover want one"); end
  endtask

  task automatic test_load_use();
    exp_t e;
    drive_instr(5'd3, 5'd8, 5'd10, 32'h33, 32'h88, 32'h100, 4'd5, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    sb.push_back('{a: 32'h42, b: 32'h100, st: 32'h88, sel: 4'd5, rd: 5'd10, rw: 1'b1, mr: 1'b0});
    tick();
    bus.in_valid = 1'b0;
    set_exm(5'd3, 1'b1, 1'b1, 32'hDEAD);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.out_valid, bus.stall} !== 2'b01) begin n_err++; $display("FAIL load_use_stall: got %b want 01", {bus.out_valid, bus.stall}); end
    tick();
    clear_bypass();
    set_mwb(5'd3, 1'b1, 32'h42);
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_err++; $display("FAIL load_use_release: got %b want 10", {bus.out_valid, bus.stall}); end
    tick();
    clear_bypass();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL load_use_valid: got %b want 1", bus.out_valid);
    end else begin
      e = sb.pop_front();
      n_vec++; if (observed() !== e) begin n_err++; $display("FAIL load_use_snoop: got %h want %h", observed(), e); end
    end
    tick();
  endtask

  task automatic test_x0();
    exp_t e;
    drive_instr(5'd0, 5'd2, 5'd6, 32'h0, 32'h22, 32'h7, 4'd1, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    sb.push_back('{a: 32'h0, b: 32'h7, st: 32'h22, sel: 4'd1, rd: 5'd6, rw: 1'b1, mr: 1'b0});
    tick();
    bus.in_valid = 1'b0;
    set_exm(5'd0, 1'b1, 1'b1, 32'hFF);
    set_mwb(5'd0, 1'b1, 32'hEE);
    @(negedge clk);
    n_vec++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_err++; $display("FAIL x0_no_stall: got %b want 10", {bus.out_valid, bus.stall}); end
    n_vec++; if (bus.out_a !== 32'h0) begin n_err++; $display("FAIL x0_no_fwd: got %h want 0", bus.out_a); end
    tick();
    clear_bypass();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL x0_valid: got %b want 1", bus.out_valid);
    end else begin
      e = sb.pop_front();
      n_vec++; if (observed() !== e) begin n_err++; $display("FAIL x0_no_snoop: got %h want %h", observed(), e); end
    end
    tick();
  endtask

  task automatic test_backpressure_flush();
    exp_t held;
    held = '{a: 32'hC0C0, b: 32'hD0D0, st: 32'hD0D0, sel: 4'd7, rd: 5'd14, rw: 1'b0, mr: 1'b1};
    drive_instr(5'd12, 5'd13, 5'd14, 32'hC0C0, 32'hD0D0, 32'h9, 4'd7, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    tick();
    drive_instr(5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'h3333, 4'd9, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
      n_vec++; if (observed() !== held) begin n_err++; $display("FAIL bp_stable[%0d]: got %h want %h", c, observed(), held); end
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    tick();
    drive_instr(5'd4, 5'd5, 5'd6, 32'h4444, 32'h5555, 32'h6666, 4'd4, 1'b0, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_beats_capture: got %b want 0", bus.out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] d1, d2, imm;
    logic [3:0]  sel;
    logic        ui;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        d1  = $urandom;
        d2  = $urandom;
        imm = $urandom;
        sel = 4'($urandom_range(0, 15));
        ui  = (c % 2 == 1);
        drive_instr(5'(c + 1), 5'(c + 20), 5'(c + 8), d1, d2, imm, sel, ui, 1'b1, ui);
        sb.push_back('{a: d1, b: (ui ? imm : d2), st: d2, sel: sel, rd: 5'(c + 8), rw: 1'b1, mr: ui});
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (c < 4) begin
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, bus.in_ready); end
      end
      if (c >= 1 && c <= 4) begin
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, bus.out_valid); end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_extra[%0d]: got handover want none", c);
        end else begin
          e = sb.pop_front();
          n_vec++; if (observed() !== e) begin n_err++; $display("FAIL b2b_out[%0d]: got %h want %h", c, observed(), e); end
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_instr(5'd3, 5'd4, 5'd5, 32'hABCD, 32'h1234, 32'h55, 4'd6, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    drive_instr(5'd7, 5'd8, 5'd9, 32'h7777, 32'h8888, 32'h99, 4'd2, 1'b0, 1'b1, 1'b0);
    set_exm(5'd3, 1'b1, 1'b1, 32'h77);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_pre: got %b want 1", bus.stall); end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_bypass();
    @(negedge clk);
    n_vec++; if ({bus.out_valid, bus.stall, bus.in_ready} !== 3'b001) begin
      n_err++; $display("FAIL rst_stall_ctrl: got %b want 001", {bus.out_valid, bus.stall, bus.in_ready});
    end
    n_vec++; if (observed() !== '0) begin n_err++; $display("FAIL rst_stall_fields: got %h want 0", observed()); end
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_instr('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    clear_bypass();

    test_reset();
    test_exm_forward();
    test_priority();
    test_load_use();
    test_x0();
    test_backpressure_flush();
    test_back_to_back();
    test_reset_mid_stall();

    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
